// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low keypad scanner with debounce and one-shot command pulses
// Scan FSM walks the columns, debounces a single-row hit, emits one pulse per press, then waits for full release.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] digit,
  output logic       load,
  output logic       bksp,
  output logic       clear,
  output logic       op_valid,
  output logic [1:0] op
);

  localparam int CMAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CMAX);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    HELD
  } state_t;

  typedef enum logic [1:0] {
    K_DIGIT,
    K_BKSP,
    K_CLEAR,
    K_OP
  } kind_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    row_meta;
  logic [3:0]    rs;
  logic [3:0]    row_pat;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [1:0]    next_col;
  logic          single_low;
  logic [1:0]    rs_idx;
  kind_t         key_kind;
  logic [3:0]    key_val;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign next_col = col_idx + 2'd1;

  // A hit counts only when exactly one row is pulled low; ghosting or chords are skipped.
  always_comb begin
    single_low = 1'b1;
    rs_idx     = 2'd0;
    case (rs)
      4'b1110: rs_idx = 2'd0;
      4'b1101: rs_idx = 2'd1;
      4'b1011: rs_idx = 2'd2;
      4'b0111: rs_idx = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  always_comb begin
    key_kind = K_DIGIT;
    key_val  = 4'd0;
    case ({row_idx, col_idx})
      4'd0:  key_val = 4'd1;
      4'd1:  key_val = 4'd2;
      4'd2:  key_val = 4'd3;
      4'd3:  key_kind = K_BKSP;
      4'd4:  key_val = 4'd4;
      4'd5:  key_val = 4'd5;
      4'd6:  key_val = 4'd6;
      4'd7:  key_kind = K_CLEAR;
      4'd8:  key_val = 4'd7;
      4'd9:  key_val = 4'd8;
      4'd10: key_val = 4'd9;
      4'd11: begin key_kind = K_OP; key_val = 4'd0; end
      4'd12: begin key_kind = K_OP; key_val = 4'd2; end
      4'd13: key_val = 4'd0;
      4'd14: begin key_kind = K_OP; key_val = 4'd3; end
      default: begin key_kind = K_OP; key_val = 4'd1; end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SCAN;
      cnt      <= '0;
      row_pat  <= 4'hF;
      row_idx  <= 2'd0;
      col_idx  <= 2'd0;
      col      <= 4'b1110;
      digit    <= 4'b1010;
      op       <= 2'b00;
      load     <= 1'b0;
      bksp     <= 1'b0;
      clear    <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      load     <= 1'b0;
      bksp     <= 1'b0;
      clear    <= 1'b0;
      op_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (single_low) begin
              row_pat <= rs;
              row_idx <= rs_idx;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= next_col;
              col     <= ~(4'b0001 << next_col);
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        DEBOUNCE: begin
          // Any deviation discards the partial count and rescans the same column.
          if (rs != row_pat) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= EMIT;
            cnt   <= '0;
            case (key_kind)
              K_DIGIT: begin
                load  <= 1'b1;
                digit <= key_val;
              end
              K_BKSP:  bksp  <= 1'b1;
              K_CLEAR: clear <= 1'b1;
              default: begin
                op_valid <= 1'b1;
                op       <= key_val[1:0];
              end
            endcase
          end else begin
            cnt <= cnt_inc;
          end
        end
        EMIT: begin
          state <= HELD;
          cnt   <= '0;
        end
        default: begin
          if (rs != 4'hF) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            state   <= SCAN;
            cnt     <= '0;
            col_idx <= next_col;
            col     <= ~(4'b0001 << next_col);
          end else begin
            cnt <= cnt_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a keypad matrix model and pulse scoreboard
// Each expected press is queued as an event; the compare process matches pulses and held registers every cycle.
module tb_keypad_scanner;

  logic       clock;
  logic       reset_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] digit;
  logic       load;
  logic       bksp;
  logic       clear;
  logic       op_valid;
  logic [1:0] op;

  logic [15:0] pressed;
  int          total = 0;
  int          bad   = 0;
  int          exp_q[$];
  int          exp_digit = 10;
  int          exp_op    = 0;
  int          keycode[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_scanner #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .row     (row),
    .col     (col),
    .digit   (digit),
    .load    (load),
    .bksp    (bksp),
    .clear   (clear),
    .op_valid(op_valid),
    .op      (op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A closed switch pulls its row low only while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event code: kind*16 + value; kind 0=load 1=bksp 2=clear 3=op.
  function automatic int key_event(input int r, input int c);
    int k;
    k = keycode[r*4+c];
    if (k < 10)  return k;
    if (k == 10) return 16;
    if (k == 11) return 32;
    if (k == 12) return 48;
    if (k == 13) return 49;
    if (k == 14) return 50;
    return 51;
  endfunction

  always @(negedge clock) begin
    int n;
    int obs;
    int e;
    if (!reset_n) begin
      exp_digit = 10;
      exp_op    = 0;
      chk("rst_col", col, 4'b1110);
      chk("rst_pulses", {load, bksp, clear, op_valid}, 0);
      chk("rst_digit", digit, 10);
      chk("rst_op", op, 0);
    end else begin
      n = int'(load) + int'(bksp) + int'(clear) + int'(op_valid);
      chk("pulse_excl", n > 1, 0);
      if (n != 0) begin
        if (load)       obs = digit;
        else if (bksp)  obs = 16;
        else if (clear) obs = 32;
        else            obs = 48 + op;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", obs, -1);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_event", obs, e);
          if (e < 16) exp_digit = e;
          if (e >= 48) exp_op = e - 48;
        end
      end
      chk("digit_held", digit, exp_digit);
      chk("op_held", op, exp_op);
      chk("col_one_low", (col == 4'b1110 || col == 4'b1101 || col == 4'b1011 || col == 4'b0111), 1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic press(input int r, input int c, input int hold);
    pressed[r*4+c] = 1'b1;
    exp_q.push_back(key_event(r, c));
    cycles(hold);
    pressed = '0;
    cycles(30);
    drain("press_drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int budget;
    reset_n = 1'b0;
    pressed = '0;
    cycles(3);
    @(negedge clock);
    chk("reset_col_lit", col, 4'b1110);
    chk("reset_digit_lit", digit, 4'b1010);
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clock);
      if (e == 2)  begin @(negedge clock); chk("scan_c0", col, 4'b1110); end
      if (e == 6)  begin @(negedge clock); chk("scan_c1", col, 4'b1101); end
      if (e == 10) begin @(negedge clock); chk("scan_c2", col, 4'b1011); end
      if (e == 14) begin @(negedge clock); chk("scan_c3", col, 4'b0111); end
    end
    cycles(1);

    // Key 7 (r2,c0), then scanning resumes at c1 after release debounce.
    pressed[8] = 1'b1;
    exp_q.push_back(7);
    cycles(40);
    pressed = '0;
    for (int e = 1; e <= 11; e++) @(posedge clock);
    @(negedge clock);
    chk("resume_c1", col, 4'b1101);
    cycles(30);
    drain("key7_drain");
    chk("key7_digit_lit", digit, 7);

    press(0, 3, 40);
    chk("after_A_digit", digit, 7);
    press(1, 3, 40);
    chk("after_B_digit", digit, 7);
    press(3, 1, 40);
    chk("key0_digit_lit", digit, 0);

    press(2, 3, 40);
    chk("op_C", op, 0);
    press(3, 3, 40);
    chk("op_D", op, 1);
    press(3, 0, 40);
    chk("op_star", op, 2);
    press(3, 2, 40);
    chk("op_hash", op, 3);
    chk("ops_digit_kept", digit, 0);

    // Bounce key 5: unstable for 30 cycles, then stable.
    for (int i = 0; i < 10; i++) begin
      pressed[5] = ~pressed[5];
      cycles(3);
    end
    press(1, 1, 40);
    chk("bounce_digit_lit", digit, 5);

    // Ghost: two rows on one column.
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    cycles(60);
    pressed = '0;
    cycles(30);
    chk("ghost_digit", digit, 5);

    // Hold 2, add 3 while held; only 2 is accepted.
    pressed[1] = 1'b1;
    exp_q.push_back(2);
    budget = 0;
    while (exp_q.size() != 0 && budget < 80) begin
      cycles(1);
      budget++;
    end
    chk("key2_timeout", budget < 80, 1);
    cycles(3);
    pressed[2] = 1'b1;
    cycles(40);
    pressed = '0;
    cycles(40);
    drain("hold_drain");
    chk("hold_digit_lit", digit, 2);

    // Reset while debouncing key 7 on column 0.
    reset_n = 1'b0;
    pressed[8] = 1'b1;
    cycles(2);
    reset_n = 1'b1;
    cycles(7);
    reset_n = 1'b0;
    cycles(2);
    pressed = '0;
    reset_n = 1'b1;
    cycles(40);
    drain("reset_abort_drain");
    chk("reset_abort_digit", digit, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
